// File: rtl/conv_pkg.sv
// Shared definitions for the convolution sequencer: FSM encoding,
// legal mask sizes and default widths.
package conv_pkg;

    localparam int BITS_PIXEL_DEF     = 8;
    localparam int BITS_DIM_DEF       = 10;
    localparam int CICLOS_TIMEOUT_DEF = 16;

    localparam logic [2:0] MASCARA_PEQUENA = 3'd3;
    localparam logic [2:0] MASCARA_GRANDE  = 3'd5;

    typedef enum logic [2:0] {
        REPOSO,
        VALIDA,
        ESPERA_VENTANA,
        DISPARO,
        ESPERA_RESULTADO,
        AVANZA
    } estado_t;

    function automatic logic mascara_legal(input logic [2:0] tamano);
        return (tamano == MASCARA_PEQUENA) || (tamano == MASCARA_GRANDE);
    endfunction

endpackage

// File: rtl/contador_ventana.sv
// Row/column position of the current output pixel, raster order,
// with wrap at the last column and a last-pixel flag.
module contador_ventana
    import conv_pkg::*;
#(
    parameter int BITS_DIM = BITS_DIM_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                limpiar,
    input  logic                avanzar,
    input  logic [BITS_DIM-1:0] ultima_columna,
    input  logic [BITS_DIM-1:0] ultima_fila,
    output logic [BITS_DIM-1:0] fila,
    output logic [BITS_DIM-1:0] columna,
    output logic                ultimo
);

    logic [BITS_DIM-1:0] fila_q, fila_d;
    logic [BITS_DIM-1:0] columna_q, columna_d;

    // next position: clear to origin, or step with wrap into the next row
    always_comb begin
        fila_d    = fila_q;
        columna_d = columna_q;
        if (limpiar) begin
            fila_d    = '0;
            columna_d = '0;
        end else if (avanzar) begin
            if (columna_q == ultima_columna) begin
                columna_d = '0;
                fila_d    = fila_q + 1'b1;
            end else begin
                columna_d = columna_q + 1'b1;
            end
        end
    end

    // position registers
    always_ff @(posedge clk) begin
        if (reset) begin
            fila_q    <= '0;
            columna_q <= '0;
        end else begin
            fila_q    <= fila_d;
            columna_q <= columna_d;
        end
    end

    assign fila    = fila_q;
    assign columna = columna_q;
    assign ultimo  = (columna_q == ultima_columna) && (fila_q == ultima_fila);

endmodule

// File: rtl/control_convolucion.sv
// Sequencer between the window builder and the convolution unit:
// walks the valid output grid, hands out one window at a time and
// turns each result into a coordinate-tagged output stream.
//
// state            | meaning
// REPOSO           | idle, waiting for inicio
// VALIDA           | checking latched mask size and dimensions
// ESPERA_VENTANA   | waiting for the window builder
// DISPARO          | one-cycle trigger/ack for the current window
// ESPERA_RESULTADO | waiting for the result strobe, timeout running
// AVANZA           | result presented, stepping to the next pixel
module control_convolucion
    import conv_pkg::*;
#(
    parameter int BITS_PIXEL     = BITS_PIXEL_DEF,
    parameter int BITS_DIM       = BITS_DIM_DEF,
    parameter int CICLOS_TIMEOUT = CICLOS_TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inicio,
    input  logic [BITS_DIM-1:0]   ancho_imagen,
    input  logic [BITS_DIM-1:0]   alto_imagen,
    input  logic [2:0]            tamano_mascara,
    input  logic                  ventana_disponible,
    output logic                  ventana_consumida,
    output logic                  ventana_pixeles_lista,
    input  logic                  pixel_calculado,
    input  logic [BITS_PIXEL-1:0] pixel_resultado,
    output logic [BITS_PIXEL-1:0] pixel_salida,
    output logic                  pixel_salida_valido,
    output logic [BITS_DIM-1:0]   fila_salida,
    output logic [BITS_DIM-1:0]   columna_salida,
    output logic                  ocupado,
    output logic                  imagen_terminada,
    output logic                  error_config,
    output logic                  error_timeout
);

    localparam int BITS_TMR = $clog2(CICLOS_TIMEOUT) + 1;
    localparam logic [BITS_TMR-1:0] TMR_CARGA = BITS_TMR'(CICLOS_TIMEOUT - 1);

    estado_t               estado_q, estado_d;
    logic [BITS_DIM-1:0]   ancho_q, ancho_d, alto_q, alto_d;
    logic [2:0]            tamano_q, tamano_d;
    logic [BITS_TMR-1:0]   timer_q, timer_d;
    logic [BITS_PIXEL-1:0] pixel_salida_q, pixel_salida_d;
    logic [BITS_DIM-1:0]   fila_salida_q, fila_salida_d;
    logic [BITS_DIM-1:0]   columna_salida_q, columna_salida_d;
    logic                  valido_q, valido_d;
    logic                  lista_q, lista_d;
    logic                  consumida_q, consumida_d;
    logic                  ocupado_q, ocupado_d;
    logic                  terminada_q, terminada_d;
    logic                  err_cfg_q, err_cfg_d;
    logic                  err_tmo_q, err_tmo_d;

    logic                  cnt_limpiar, cnt_avanzar, cnt_ultimo;
    logic [BITS_DIM-1:0]   cnt_fila, cnt_columna;
    logic [BITS_DIM-1:0]   tamano_ext;

    assign tamano_ext = BITS_DIM'(tamano_q);

    contador_ventana #(
        .BITS_DIM(BITS_DIM)
    ) u_contador (
        .clk           (clk),
        .reset         (reset),
        .limpiar       (cnt_limpiar),
        .avanzar       (cnt_avanzar),
        .ultima_columna(ancho_q - tamano_ext),
        .ultima_fila   (alto_q - tamano_ext),
        .fila          (cnt_fila),
        .columna       (cnt_columna),
        .ultimo        (cnt_ultimo)
    );

    // next state and next registered outputs; strobes are derived from the
    // next state so they are high exactly while the FSM sits in that state
    always_comb begin
        estado_d         = estado_q;
        ancho_d          = ancho_q;
        alto_d           = alto_q;
        tamano_d         = tamano_q;
        timer_d          = timer_q;
        pixel_salida_d   = pixel_salida_q;
        fila_salida_d    = fila_salida_q;
        columna_salida_d = columna_salida_q;
        valido_d         = 1'b0;
        terminada_d      = 1'b0;
        err_cfg_d        = 1'b0;
        err_tmo_d        = 1'b0;
        cnt_limpiar      = 1'b0;
        cnt_avanzar      = 1'b0;
        case (estado_q)
            REPOSO: begin
                if (inicio) begin
                    ancho_d  = ancho_imagen;
                    alto_d   = alto_imagen;
                    tamano_d = tamano_mascara;
                    estado_d = VALIDA;
                end
            end
            VALIDA: begin
                if (!mascara_legal(tamano_q) || (ancho_q < tamano_ext) || (alto_q < tamano_ext)) begin
                    err_cfg_d = 1'b1;
                    estado_d  = REPOSO;
                end else begin
                    cnt_limpiar = 1'b1;
                    estado_d    = ESPERA_VENTANA;
                end
            end
            ESPERA_VENTANA: begin
                if (ventana_disponible) estado_d = DISPARO;
            end
            DISPARO: begin
                timer_d  = TMR_CARGA;
                estado_d = ESPERA_RESULTADO;
            end
            ESPERA_RESULTADO: begin
                // a strobe on the final allowed cycle still wins over the timeout
                if (pixel_calculado) begin
                    pixel_salida_d   = pixel_resultado;
                    fila_salida_d    = cnt_fila;
                    columna_salida_d = cnt_columna;
                    valido_d         = 1'b1;
                    estado_d         = AVANZA;
                end else if (timer_q == '0) begin
                    err_tmo_d = 1'b1;
                    estado_d  = REPOSO;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            AVANZA: begin
                if (cnt_ultimo) begin
                    terminada_d = 1'b1;
                    estado_d    = REPOSO;
                end else begin
                    cnt_avanzar = 1'b1;
                    estado_d    = ESPERA_VENTANA;
                end
            end
            default: estado_d = REPOSO;
        endcase
        lista_d     = (estado_d == DISPARO);
        consumida_d = (estado_d == DISPARO);
        ocupado_d   = (estado_d != REPOSO);
    end

    // state, configuration and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q         <= REPOSO;
            ancho_q          <= '0;
            alto_q           <= '0;
            tamano_q         <= '0;
            timer_q          <= '0;
            pixel_salida_q   <= '0;
            fila_salida_q    <= '0;
            columna_salida_q <= '0;
            valido_q         <= 1'b0;
            lista_q          <= 1'b0;
            consumida_q      <= 1'b0;
            ocupado_q        <= 1'b0;
            terminada_q      <= 1'b0;
            err_cfg_q        <= 1'b0;
            err_tmo_q        <= 1'b0;
        end else begin
            estado_q         <= estado_d;
            ancho_q          <= ancho_d;
            alto_q           <= alto_d;
            tamano_q         <= tamano_d;
            timer_q          <= timer_d;
            pixel_salida_q   <= pixel_salida_d;
            fila_salida_q    <= fila_salida_d;
            columna_salida_q <= columna_salida_d;
            valido_q         <= valido_d;
            lista_q          <= lista_d;
            consumida_q      <= consumida_d;
            ocupado_q        <= ocupado_d;
            terminada_q      <= terminada_d;
            err_cfg_q        <= err_cfg_d;
            err_tmo_q        <= err_tmo_d;
        end
    end

    assign ventana_consumida     = consumida_q;
    assign ventana_pixeles_lista = lista_q;
    assign pixel_salida          = pixel_salida_q;
    assign pixel_salida_valido   = valido_q;
    assign fila_salida           = fila_salida_q;
    assign columna_salida        = columna_salida_q;
    assign ocupado               = ocupado_q;
    assign imagen_terminada      = terminada_q;
    assign error_config          = err_cfg_q;
    assign error_timeout         = err_tmo_q;

endmodule
